// File: rtl/cardinal_dmem_responder_if.sv
// CPU data-memory port plus host preload port of the cardinal data memory responder.
// Vectors are numbered MSB-first (bit 0 is the most significant bit).
interface cardinal_dmem_responder_if #(
    parameter int AW = 8
);
    logic          dmem_En;
    logic          dmem_WrEn;
    logic [0:31]   dmem_addr;
    logic [0:63]   dmem_data_out;
    logic [0:63]   dmem_data_in;
    logic          host_we;
    logic [0:AW-1] host_addr;
    logic [0:63]   host_wdata;
    logic          host_ack;

    modport master (
        output dmem_En, dmem_WrEn, dmem_addr, dmem_data_out,
        output host_we, host_addr, host_wdata,
        input  dmem_data_in, host_ack
    );

    modport slave (
        input  dmem_En, dmem_WrEn, dmem_addr, dmem_data_out,
        input  host_we, host_addr, host_wdata,
        output dmem_data_in, host_ack
    );
endinterface

// File: rtl/cardinal_dmem_responder.sv
// 2^AW x 64-bit data memory answering a CPU that presents every access twice.
// The second copy is recognised and not re-committed; a host port preloads words when the CPU is not writing.
module cardinal_dmem_responder #(
    parameter int AW = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    cardinal_dmem_responder_if.slave bus,
    output logic [0:15]              rd_count,
    output logic [0:15]              wr_count,
    output logic                     addr_err
);
    typedef enum logic {S_IDLE, S_HELD} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [0:63]   r_mem [0:(1<<AW)-1];
    logic [0:63]   r_data_in;
    logic          r_host_ack;
    logic [0:15]   r_rd_count;
    logic [0:15]   r_wr_count;
    logic          r_addr_err;

    logic          r_prev_en;
    logic          r_prev_wren;
    logic [0:31]   r_prev_addr;
    logic [0:63]   r_prev_data;

    logic [0:AW-1] w_idx;
    logic          w_oor;
    logic          w_same;
    logic          w_new;
    logic          w_rd_req;
    logic          w_cpu_commit;
    logic          w_host_commit;

    function automatic logic [0:15] sat_inc(input logic [0:15] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_idx  = bus.dmem_addr[32-AW:31];
    assign w_oor  = |bus.dmem_addr[0:31-AW];
    assign w_same = r_prev_en && bus.dmem_En
                 && (bus.dmem_WrEn     == r_prev_wren)
                 && (bus.dmem_addr     == r_prev_addr)
                 && (bus.dmem_data_out == r_prev_data);

    // HELD means the previous cycle started a logical access, so an identical copy now is its repeat
    always_comb begin
        w_state_nxt = r_state;
        w_new       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.dmem_En) begin
                    w_new       = 1'b1;
                    w_state_nxt = S_HELD;
                end
            end
            S_HELD: begin
                if (w_same) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.dmem_En) begin
                    w_new       = 1'b1;
                    w_state_nxt = S_HELD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_rd_req      = !reset && bus.dmem_En && !bus.dmem_WrEn;
    assign w_cpu_commit  = !reset && w_new && bus.dmem_WrEn && !w_oor;
    assign w_host_commit = !reset && bus.host_we && !w_cpu_commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_prev_en   <= bus.dmem_En;
        r_prev_wren <= bus.dmem_WrEn;
        r_prev_addr <= bus.dmem_addr;
        r_prev_data <= bus.dmem_data_out;
    end

    // Array has no reset; a write lands before the next cycle's read, so no bypass is needed
    always_ff @(posedge clk) begin
        if (w_cpu_commit) begin
            r_mem[w_idx] <= bus.dmem_data_out;
        end else if (w_host_commit) begin
            r_mem[bus.host_addr] <= bus.host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_in  <= '0;
            r_host_ack <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_rd_req) begin
                r_data_in <= w_oor ? 64'd0 : r_mem[w_idx];
            end
            r_host_ack <= w_host_commit;
            if (w_new && !bus.dmem_WrEn) begin
                r_rd_count <= sat_inc(r_rd_count);
            end
            if (w_new && bus.dmem_WrEn) begin
                r_wr_count <= sat_inc(r_wr_count);
            end
            if (bus.dmem_En && w_oor) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign bus.dmem_data_in = r_data_in;
    assign bus.host_ack     = r_host_ack;
    assign rd_count         = r_rd_count;
    assign wr_count         = r_wr_count;
    assign addr_err         = r_addr_err;
endmodule

// File: tb/tb_cardinal_dmem_responder.sv
// Testbench for cardinal_dmem_responder: directed scenarios plus randomized traffic
// checked against a behavioural model of the memory, dedup rule, counters and host port.
`timescale 1ns/1ps
module tb_cardinal_dmem_responder;
    localparam int AW = 7;  // 128 words, so word index 200 lies beyond the array
    localparam int NW = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:15] rd_count;
    logic [0:15] wr_count;
    logic        addr_err;

    cardinal_dmem_responder_if #(.AW(AW)) bus();

    cardinal_dmem_responder #(.AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .rd_count (rd_count),
        .wr_count (wr_count),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    logic [0:63] m_mem [0:NW-1];
    logic [0:63] m_data_in;
    logic        m_ack;
    int          m_rd;
    int          m_wr;
    logic        m_err;
    logic        m_prev_new;
    logic        m_prev_wren;
    logic [0:31] m_prev_addr;
    logic [0:63] m_prev_data;

    function automatic logic [0:63] rand64();
        return {$urandom, $urandom};
    endfunction

    // Drive one cycle of inputs, let the edge pass, advance the model, then settle 1ns past the edge
    task automatic step(input logic rst, input logic en, input logic wren, input logic [0:31] addr,
                        input logic [0:63] d, input logic hwe, input int ha, input logic [0:63] hd);
        logic is_rep;
        logic is_new;
        logic oor;
        logic cpu_wr;
        logic host_wr;
        int   idx;
        reset             = rst;
        bus.dmem_En       = en;
        bus.dmem_WrEn     = wren;
        bus.dmem_addr     = addr;
        bus.dmem_data_out = d;
        bus.host_we       = hwe;
        bus.host_addr     = ha[AW-1:0];
        bus.host_wdata    = hd;
        @(posedge clk);
        if (rst) begin
            m_data_in  = '0;
            m_ack      = 1'b0;
            m_rd       = 0;
            m_wr       = 0;
            m_err      = 1'b0;
            m_prev_new = 1'b0;
        end else begin
            oor    = (addr >= 32'(NW));
            idx    = int'(addr % 32'(NW));
            // A request repeats only the logical access that began in the immediately preceding cycle
            is_rep = m_prev_new && en && (wren == m_prev_wren) && (addr == m_prev_addr) && (d == m_prev_data);
            is_new = en && !is_rep;
            if (en && !wren) m_data_in = oor ? 64'd0 : m_mem[idx];
            if (en && oor) m_err = 1'b1;
            if (is_new && wren)  m_wr = (m_wr < 65535) ? m_wr + 1 : 65535;
            if (is_new && !wren) m_rd = (m_rd < 65535) ? m_rd + 1 : 65535;
            cpu_wr  = is_new && wren && !oor;
            host_wr = hwe && !cpu_wr;
            m_ack   = host_wr;
            if (cpu_wr) m_mem[idx] = d;
            else if (host_wr) m_mem[ha] = hd;
            m_prev_new = is_new;
        end
        m_prev_wren = wren;
        m_prev_addr = addr;
        m_prev_data = d;
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 0, 64'd0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 32'd4, 64'hDEAD, 1'b1, 4, 64'hBEEF);
        step(1'b1, 1'b1, 1'b0, 32'd4, 64'hDEAD, 1'b1, 4, 64'hBEEF);
        n_checks++; if (bus.dmem_data_in !== 64'd0) begin n_fail++; $display("FAIL reset_data_in: got %h expected 0", bus.dmem_data_in); end
        n_checks++; if (bus.host_ack !== 1'b0) begin n_fail++; $display("FAIL reset_host_ack: got %b expected 0", bus.host_ack); end
        n_checks++; if (rd_count !== 16'd0) begin n_fail++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
        n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count); end
        n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    endtask

    task automatic test_preload();
        for (int i = 0; i < NW; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b1, i, rand64());
            n_checks++; if (bus.host_ack !== 1'b1) begin n_fail++; $display("FAIL preload_ack[%0d]: got %b expected 1", i, bus.host_ack); end
        end
        step(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.host_ack !== 1'b0) begin n_fail++; $display("FAIL preload_ack_idle: got %b expected 0", bus.host_ack); end
    endtask

    task automatic test_host_preload_read();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 5, 64'h0123456789ABCDEF);
        step(1'b0, 1'b1, 1'b0, 32'd5, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.dmem_data_in !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL preload_read_1: got %h expected 0123456789abcdef", bus.dmem_data_in); end
        step(1'b0, 1'b1, 1'b0, 32'd5, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.dmem_data_in !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL preload_read_2: got %h expected 0123456789abcdef", bus.dmem_data_in); end
        n_checks++; if (rd_count !== 16'd1) begin n_fail++; $display("FAIL preload_rd_count: got %0d expected 1", rd_count); end
        step(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.dmem_data_in !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL idle_hold_data: got %h expected 0123456789abcdef", bus.dmem_data_in); end
    endtask

    task automatic test_store_read();
        do_reset();
        step(1'b0, 1'b1, 1'b1, 32'd7, {16{4'hA}}, 1'b0, 0, 64'd0);
        n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL store_wr_issue: got %0d expected 1", wr_count); end
        step(1'b0, 1'b1, 1'b1, 32'd7, {16{4'hA}}, 1'b0, 0, 64'd0);
        step(1'b0, 1'b1, 1'b0, 32'd7, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.dmem_data_in !== {16{4'hA}}) begin n_fail++; $display("FAIL store_readback: got %h expected aaaaaaaaaaaaaaaa", bus.dmem_data_in); end
        n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL store_wr_count: got %0d expected 1", wr_count); end
        n_checks++; if (rd_count !== 16'd1) begin n_fail++; $display("FAIL store_rd_count: got %0d expected 1", rd_count); end
    endtask

    task automatic test_repeat_dedup();
        logic [15:0] exp_wr [0:3];
        exp_wr = '{16'd1, 16'd1, 16'd2, 16'd2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'd9, {16{4'h5}}, 1'b0, 0, 64'd0);
            n_checks++; if (wr_count !== exp_wr[i]) begin n_fail++; $display("FAIL dedup_wr_count[N+%0d]: got %0d expected %0d", i, wr_count, exp_wr[i]); end
        end
        n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL dedup_err_inrange: got %b expected 0", addr_err); end
        step(1'b0, 1'b1, 1'b0, 32'd200, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.dmem_data_in !== 64'd0) begin n_fail++; $display("FAIL oor200_data: got %h expected 0", bus.dmem_data_in); end
        n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL oor200_err: got %b expected 1", addr_err); end
        n_checks++; if (rd_count !== 16'd1) begin n_fail++; $display("FAIL oor200_rd_count: got %0d expected 1", rd_count); end
    endtask

    task automatic test_out_of_range();
        logic [0:63] w3;
        w3 = m_mem[3];
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'd3, 64'd0, 1'b0, 0, 64'd0);
        step(1'b0, 1'b1, 1'b0, 32'h00010003, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.dmem_data_in !== 64'd0) begin n_fail++; $display("FAIL oor_read_data: got %h expected 0", bus.dmem_data_in); end
        n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_read_err: got %b expected 1", addr_err); end
        step(1'b0, 1'b1, 1'b1, 32'h00010003, ~w3, 1'b0, 0, 64'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 0, 64'd0);
        step(1'b0, 1'b1, 1'b0, 32'd3, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.dmem_data_in !== w3) begin n_fail++; $display("FAIL oor_mem_unchanged: got %h expected %h", bus.dmem_data_in, w3); end
        n_checks++; if (rd_count !== 16'd3) begin n_fail++; $display("FAIL oor_rd_count: got %0d expected 3", rd_count); end
        n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL oor_wr_count: got %0d expected 1", wr_count); end
        n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_err_sticky: got %b expected 1", addr_err); end
    endtask

    task automatic test_host_priority();
        logic [0:63] dc;
        logic [0:63] dh;
        dc = rand64();
        dh = ~dc;
        do_reset();
        step(1'b0, 1'b1, 1'b1, 32'd10, dc, 1'b1, 11, dh);
        n_checks++; if (bus.host_ack !== 1'b0) begin n_fail++; $display("FAIL host_blocked_ack: got %b expected 0", bus.host_ack); end
        step(1'b0, 1'b1, 1'b1, 32'd10, dc, 1'b1, 11, dh);
        n_checks++; if (bus.host_ack !== 1'b1) begin n_fail++; $display("FAIL host_commit_ack: got %b expected 1", bus.host_ack); end
        step(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.host_ack !== 1'b0) begin n_fail++; $display("FAIL host_ack_pulse: got %b expected 0", bus.host_ack); end
        step(1'b0, 1'b1, 1'b0, 32'd11, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.dmem_data_in !== dh) begin n_fail++; $display("FAIL host_word: got %h expected %h", bus.dmem_data_in, dh); end
        step(1'b0, 1'b1, 1'b0, 32'd10, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.dmem_data_in !== dc) begin n_fail++; $display("FAIL cpu_word: got %h expected %h", bus.dmem_data_in, dc); end
        n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL host_prio_wr_count: got %0d expected 1", wr_count); end
    endtask

    task automatic test_random();
        logic        rst;
        logic        en;
        logic        wren;
        logic [0:31] addr;
        logic [0:63] d;
        en   = 1'b0;
        wren = 1'b0;
        addr = '0;
        d    = '0;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                en   = ($urandom_range(0, 4) != 0);
                wren = 1'($urandom_range(0, 1));
                addr = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
                d    = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 3)) : rand64();
            end
            rst = ($urandom_range(0, 199) == 0);
            step(rst, en, wren, addr, d, ($urandom_range(0, 2) == 0), $urandom_range(0, 15), rand64());
            n_checks++; if (bus.dmem_data_in !== m_data_in) begin n_fail++; $display("FAIL rand_data_in[%0d]: got %h expected %h", i, bus.dmem_data_in, m_data_in); end
            n_checks++; if (bus.host_ack !== m_ack) begin n_fail++; $display("FAIL rand_host_ack[%0d]: got %b expected %b", i, bus.host_ack, m_ack); end
            n_checks++; if (rd_count !== 16'(m_rd)) begin n_fail++; $display("FAIL rand_rd_count[%0d]: got %0d expected %0d", i, rd_count, m_rd); end
            n_checks++; if (wr_count !== 16'(m_wr)) begin n_fail++; $display("FAIL rand_wr_count[%0d]: got %0d expected %0d", i, wr_count, m_wr); end
            n_checks++; if (addr_err !== m_err) begin n_fail++; $display("FAIL rand_addr_err[%0d]: got %b expected %b", i, addr_err, m_err); end
        end
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'd12, 64'(i), 1'b0, 0, 64'd0);
        end
        n_checks++; if (wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffff", wr_count); end
        step(1'b0, 1'b1, 1'b1, 32'd12, 64'd65535, 1'b0, 0, 64'd0);
        n_checks++; if (wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", wr_count); end
        step(1'b0, 1'b1, 1'b1, 32'd13, 64'hC0FFEE, 1'b0, 0, 64'd0);
        step(1'b1, 1'b1, 1'b1, 32'd13, 64'hC0FFEE, 1'b0, 0, 64'd0);
        n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL midheld_reset_wr: got %0d expected 0", wr_count); end
        n_checks++; if (rd_count !== 16'd0) begin n_fail++; $display("FAIL midheld_reset_rd: got %0d expected 0", rd_count); end
        step(1'b0, 1'b1, 1'b1, 32'd13, 64'hC0FFEE, 1'b0, 0, 64'd0);
        n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL post_reset_counted: got %0d expected 1", wr_count); end
        step(1'b0, 1'b1, 1'b0, 32'd13, 64'd0, 1'b0, 0, 64'd0);
        n_checks++; if (bus.dmem_data_in !== 64'hC0FFEE) begin n_fail++; $display("FAIL post_reset_word: got %h expected c0ffee", bus.dmem_data_in); end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_host_preload_read();
        test_store_read();
        test_repeat_dedup();
        test_out_of_range();
        test_host_priority();
        test_random();
        test_saturation_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cardinal_dmem_responder.md
CARDINAL_DMEM_RESPONDER -- requirements
Module: cardinal_dmem_responder

Interface
REQ-001 Parameter: AW, 8, word-index width; the array holds 2^AW words of 64 bits.
REQ-002 Port: clk  input  1  clock; all state changes on posedge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: dmem_En  input  1  CPU access request for this cycle.
REQ-005 Port: dmem_WrEn  input  1  request is a write when high and dmem_En is high.
REQ-006 Port: dmem_addr  input  [0:31]  word address; bits [32-AW:31] index the array.
REQ-007 Port: dmem_data_out  input  [0:63]  CPU store data.
REQ-008 Port: dmem_data_in  output  [0:63]  registered load data returned to the CPU.
REQ-009 Port: host_we  input  1  preload write request, lower priority than the CPU.
REQ-010 Port: host_addr  input  [0:AW-1]  preload word index.
REQ-011 Port: host_wdata  input  [0:63]  preload data.
REQ-012 Port: host_ack  output  1  registered; high for one cycle after a host write commits.
REQ-013 Port: rd_count  output  [0:15]  saturating count of logical reads.
REQ-014 Port: wr_count  output  [0:15]  saturating count of committed CPU writes.
REQ-015 Port: addr_err  output  1  sticky out-of-range flag.

Function
REQ-016 Bit 0 is the MSB of every vector; data is stored and returned with no byte reordering.
REQ-017 Read latency: dmem_data_in in cycle k+1 SHALL equal the array word addressed in cycle k, when cycle k has dmem_En=1 and dmem_WrEn=0.
REQ-018 In a cycle with no read request, dmem_data_in SHALL hold its previous value in the next cycle.
REQ-019 The CPU presents each access for two consecutive identical cycles (issue, then held). Dedup FSM states: IDLE, HELD.
REQ-020 IDLE: on dmem_En=1, treat as a new logical access (commit the write or count the read) -> HELD; otherwise stay in IDLE.
REQ-021 HELD: if {En, WrEn, addr, data} equals the previous cycle's values, the request is a repeat: no write commit, no count increment, read still serviced -> IDLE.
REQ-022 HELD: a differing request with En=1 is a new logical access -> HELD; En=0 -> IDLE.
REQ-023 The same store issued at cycles N and N+2 SHALL commit twice (N and N+2); cycle N+1 is suppressed.
REQ-024 Out of range: dmem_addr bits [0:31-AW] are non-zero.
REQ-025 Out-of-range read returns 64'b0 in the next cycle.
REQ-026 Out-of-range write is dropped.
REQ-027 Any out-of-range request sets addr_err until reset; it is still counted as a logical access.
REQ-028 A host write commits only in cycles without a CPU write commit.
REQ-029 If a host write is blocked, the host SHALL hold host_we; host_ack pulses in the cycle after the commit.
REQ-030 host_ack stays low for repeat-suppressed CPU cycles only if the host was blocked that cycle; a host write in a suppressed cycle commits.
REQ-031 rd_count and wr_count increment by 1 per logical access and saturate at 16'hFFFF.
REQ-032 A read of an address written in the previous cycle SHALL return the new data.

Reset
REQ-033 Reset SHALL clear dmem_data_in, host_ack, rd_count, wr_count and addr_err to 0, and force the FSM to IDLE.
REQ-034 Array contents SHALL be unaffected by reset.
REQ-035 Requests present in a reset cycle are ignored.
REQ-036 A request held across reset deassertion is a new logical access.

Verification
REQ-037 Host preload word 5 = 64'h0123456789ABCDEF; CPU read addr 5 held 2 cycles -> data valid both following cycles, rd_count=1.
REQ-038 CPU store addr 7 data 64'hAA..AA held 2 cycles, then read addr 7 -> returns 64'hAA..AA, wr_count=1.
REQ-039 Identical store at cycles N, N+1, N+2, N+3 -> wr_count=2; read of addr 200 at N+4 -> 0, addr_err=1, rd_count=1.
REQ-040 Read with dmem_addr=32'h00010003 -> dmem_data_in=0, addr_err=1, memory unchanged.
REQ-041 host_we asserted during a CPU store-issue cycle -> host commits one cycle later, host_ack one cycle after that.
REQ-042 wr_count preset to 16'hFFFF by 65535 stores, one more store -> count stays 16'hFFFF; reset mid-HELD -> all counters 0 and the next request is counted.
